// File: rtl/spi_reg_bridge.sv
// SPI-slave (mode 0) to register-bus bridge. SPI pins are asynchronous and
// oversampled in the clk domain; frames decode into one-clk r_valid strobes.
// Frame: 16-bit command {wen, 3'b0, addr}, then 32 write bits, or TURN_B dummy
// bits followed by 32 read bits shifted out on spi_do.
// Optional feature: define SPIR_AUTOINC_EN for burst access with r_addr
// auto-increment; without it one access is made per frame.
module spi_reg_bridge #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned TURN_B = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_clk,
  input  logic              spi_ncs,
  input  logic              spi_di,
  output logic              spi_do,
  output logic              r_valid,
  output logic              r_wen,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  input  logic [31:0]       r_rdata
);

`ifdef SPIR_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StCmd, StWdata, StTurn, StRdata, StDone} state_e;

  logic [2:0]  sclk_q;
  logic [1:0]  ncs_q;
  logic [1:0]  di_q;
  logic        sclk_rise, sclk_fall, ncs_s, di_s;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [30:0] in_sr_q;
  logic [31:0] out_sr_q;
  logic        armed_q;
  logic        burst_q;

  // Two-flop synchronisers; the third spi_clk flop provides edge detection.
  // ncs resets low so a frame cut by reset is only re-armed once ncs is seen high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q <= '0;
      ncs_q  <= '0;
      di_q   <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk};
      ncs_q  <= {ncs_q[0], spi_ncs};
      di_q   <= {di_q[0], spi_di};
    end
  end

  // Synchronised pin views and edge strobes.
  always_comb begin
    sclk_rise = sclk_q[1] & ~sclk_q[2];
    sclk_fall = ~sclk_q[1] & sclk_q[2];
    ncs_s     = ncs_q[1];
    di_s      = di_q[1];
  end

  // Frame FSM with registered bus and MISO outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      in_sr_q  <= '0;
      out_sr_q <= '0;
      armed_q  <= 1'b0;
      burst_q  <= 1'b0;
      r_valid  <= 1'b0;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      spi_do   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (ncs_s) begin
        state_q <= StIdle;
        armed_q <= 1'b1;
        spi_do  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (armed_q) begin
              state_q  <= StCmd;
              cnt_q    <= '0;
              in_sr_q  <= '0;
              out_sr_q <= '0;
              burst_q  <= 1'b0;
            end
          end
          StCmd: begin
            if (sclk_rise) begin
              in_sr_q <= {in_sr_q[29:0], di_s};
              cnt_q   <= cnt_q + 6'd1;
              if (cnt_q == 6'd15) begin
                cnt_q  <= '0;
                r_addr <= {in_sr_q[ADDR_W-2:0], di_s};
                r_wen  <= in_sr_q[14];
                if (in_sr_q[14]) begin
                  state_q <= StWdata;
                end else begin
                  // Read strobe fires now so data is ready before turnaround ends.
                  state_q <= StTurn;
                  r_valid <= 1'b1;
                end
              end
            end
          end
          StWdata: begin
            if (sclk_rise) begin
              in_sr_q <= {in_sr_q[29:0], di_s};
              cnt_q   <= cnt_q + 6'd1;
              if (cnt_q == 6'd31) begin
                cnt_q   <= '0;
                r_wdata <= {in_sr_q, di_s};
                r_valid <= 1'b1;
                r_wen   <= 1'b1;
                if (burst_q) r_addr <= r_addr + ADDR_W'(1);
                if (AutoInc) burst_q <= 1'b1;
                else         state_q <= StDone;
              end
            end
          end
          StTurn: begin
            if (sclk_rise) begin
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q == 6'(TURN_B - 1)) begin
                state_q <= StRdata;
                cnt_q   <= '0;
              end
            end
          end
          StRdata: begin
            if (sclk_fall && cnt_q != 6'd32) begin
              spi_do   <= out_sr_q[31];
              out_sr_q <= {out_sr_q[30:0], 1'b0};
              cnt_q    <= cnt_q + 6'd1;
              if (AutoInc && cnt_q == 6'd31) begin
                // Prefetch next word; its bit 31 goes out on the following fall.
                cnt_q   <= '0;
                r_valid <= 1'b1;
                r_wen   <= 1'b0;
                r_addr  <= r_addr + ADDR_W'(1);
              end
            end else if (sclk_rise && cnt_q == 6'd32) begin
              // Bit 0 has now been sampled by the master.
              state_q <= StDone;
              spi_do  <= 1'b0;
            end
          end
          StDone: begin
            spi_do <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
      // Read data is captured the clk after the read strobe.
      if (r_valid && !r_wen) out_sr_q <= r_rdata;
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed frames plus random frames,
// compared against a frame-level reference model.
module tb_spi_reg_bridge;

`ifdef SPIR_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct packed {
    logic        wen;
    logic [11:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_ncs = 1'b1;
  logic        spi_di = 1'b0;
  logic        spi_do;
  logic        r_valid;
  logic        r_wen;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] rd_base = 32'h0;

  acc_t         got_q[$];
  acc_t         exp_q[$];
  logic [127:0] miso_v;
  logic [127:0] exp_miso;
  int           do_ones = 0;
  int           n_chk = 0;
  int           n_err = 0;

  spi_reg_bridge #(.ADDR_W(12), .TURN_B(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .spi_clk (spi_clk),
    .spi_ncs (spi_ncs),
    .spi_di  (spi_di),
    .spi_do  (spi_do),
    .r_valid (r_valid),
    .r_wen   (r_wen),
    .r_addr  (r_addr),
    .r_wdata (r_wdata),
    .r_rdata (r_rdata)
  );

  always #8 clk = ~clk;

  // Register space: each word reads as base + address.
  assign r_rdata = rd_base + {20'd0, r_addr};

  always @(negedge clk) begin
    if (r_valid === 1'b1) got_q.push_back(acc_t'({r_wen, r_addr, r_wdata}));
    if (spi_do === 1'b1) do_ones++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode-0 master at spi_clk = clk/8; samples MISO on each rise.
  task automatic spi_frame(input logic [127:0] mosi, input int nbits, input bit end_frame);
    miso_v  = '0;
    spi_ncs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_di = mosi[127-i];
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      miso_v[127-i] = spi_do;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (8) @(negedge clk);
    if (end_frame) begin
      spi_ncs = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  // Frame-level model: which accesses a frame of nbits produces, and the MISO stream.
  task automatic model(input logic [127:0] mosi, input int nbits);
    logic [15:0] cmd;
    logic [11:0] a;
    logic [31:0] w;
    acc_t        e;
    int          words;
    int          b;
    exp_q.delete();
    exp_miso = '0;
    cmd = mosi[127:112];
    if (nbits >= 16) begin
      if (cmd[15]) begin
        words = (nbits - 16) / 32;
        if (!AUTO && words > 1) words = 1;
        for (int k = 0; k < words; k++) begin
          a       = cmd[11:0] + 12'(k);
          e.wen   = 1'b1;
          e.addr  = a;
          e.wdata = mosi[111-32*k -: 32];
          exp_q.push_back(e);
        end
      end else begin
        words = 1;
        if (AUTO && nbits >= 23) words = 1 + (nbits - 23) / 32;
        for (int k = 0; k < words; k++) begin
          a       = cmd[11:0] + 12'(k);
          e.wen   = 1'b0;
          e.addr  = a;
          e.wdata = '0;
          exp_q.push_back(e);
          w = rd_base + {20'd0, a};
          for (int j = 0; j < 32; j++) begin
            b = 24 + 32 * k + j;
            if (b < nbits) exp_miso[127-b] = w[31-j];
          end
        end
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, ".wen"}, 64'(got_q[i].wen), 64'(exp_q[i].wen));
      chk({tag, ".addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      if (exp_q[i].wen) chk({tag, ".wdata"}, 64'(got_q[i].wdata), 64'(exp_q[i].wdata));
    end
    chk({tag, ".miso_hi"}, miso_v[127:64], exp_miso[127:64]);
    chk({tag, ".miso_lo"}, miso_v[63:0], exp_miso[63:0]);
  endtask

  task automatic run_frame(input string tag, input logic [127:0] mosi, input int nbits);
    model(mosi, nbits);
    got_q.delete();
    spi_frame(mosi, nbits, 1'b1);
    compare(tag);
  endtask

  initial begin
    logic [127:0] v;
    int           kind;
    int           nb;

    // Reset state
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst.r_valid", 64'(r_valid), 64'd0);
    chk("rst.r_wen", 64'(r_wen), 64'd0);
    chk("rst.r_addr", 64'(r_addr), 64'd0);
    chk("rst.r_wdata", 64'(r_wdata), 64'd0);
    chk("rst.spi_do", 64'(spi_do), 64'd0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);

    // 1: single write
    run_frame("t1", {16'h8010, 32'hDEADBEEF, 80'h0}, 48);
    if (got_q.size() > 0) begin
      chk("t1.addr_const", 64'(got_q[0].addr), 64'h010);
      chk("t1.wdata_const", 64'(got_q[0].wdata), 64'hDEADBEEF);
    end

    // 2: single read returning 0x12345678 at 0x801
    rd_base = 32'h12345678 - 32'h801;
    run_frame("t2", {16'h0801, 112'h0}, 56);
    chk("t2.rdata_const", 64'(miso_v[103:72]), 64'h12345678);

    // 3: write aborted after 20 data bits, then a normal write
    run_frame("t3a", {16'h8055, 32'hCAFEF00D, 80'h0}, 36);
    run_frame("t3b", {16'h8056, 32'h0BADC0DE, 80'h0}, 48);

    // 4: reset during read turnaround
    rd_base = $urandom;
    spi_frame({16'h0123, 112'h0}, 20, 1'b0);
    got_q.delete();
    reset_n = 1'b0;
    #1;
    chk("t4.r_valid", 64'(r_valid), 64'd0);
    chk("t4.r_wen", 64'(r_wen), 64'd0);
    chk("t4.r_addr", 64'(r_addr), 64'd0);
    chk("t4.r_wdata", 64'(r_wdata), 64'd0);
    chk("t4.spi_do", 64'(spi_do), 64'd0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    v = {$urandom, $urandom, $urandom, $urandom};
    spi_frame(v, 36, 1'b1);
    chk("t4.no_strobe", 64'(got_q.size()), 64'd0);
    chk("t4.no_miso", miso_v[127:64], 64'd0);
    run_frame("t4b", {16'h0801, 112'h0}, 56);

    // 5: two-word write at 0xFFF (wraps under auto-increment)
    run_frame("t5", {16'h8FFF, 32'h1, 32'h2, 48'h0}, 80);

    // 6: write plus 40 extra clocks; MISO must never go high
    do_ones = 0;
    run_frame("t6", {16'h8000, 112'h0}, 88);
    chk("t6.do_low", 64'(do_ones), 64'd0);

    // Random frames
    for (int f = 0; f < 20; f++) begin
      v       = {$urandom, $urandom, $urandom, $urandom};
      rd_base = $urandom;
      kind    = $urandom_range(0, 3);
      case (kind)
        0: begin v[127] = 1'b1; nb = 48; end
        1: begin v[127] = 1'b0; nb = 56; end
        2: nb = $urandom_range(10, 120);
        default: nb = 80;
      endcase
      run_frame($sformatf("rnd%0d", f), v, nb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
